// File: rtl/tile_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tile_resolver
//  Purpose  : Reads a finished tile back from the tile buffer in raster order,
//             composites every pixel over a latched background colour,
//             converts the u0.10 channels to 8 bits and streams the pixels
//             with their screen coordinates over a valid/ready handshake.
//             Each tile word can optionally be zeroed right after it is read.
//
//  Ports    : clk, reset_n        clock, synchronous active-low reset
//             start               begin a resolve (accepted only when idle)
//             tile_px, tile_py    tile origin in pixels, latched on start
//             bg_r, bg_g, bg_b    background colour, latched on start
//             clear_en            zero each word after reading, latched
//             busy, done          activity flag and completion pulse
//             tb_rd_addr/_data    tile buffer read port (1-cycle latency)
//             tb_wr_addr/_data/_en tile buffer clear port
//             out_valid/_ready    output pixel handshake
//             out_x, out_y, out_rgb  pixel coordinates and {B,G,R} colour
//
//  Revision : 1.0  initial release
// ============================================================================
module tile_resolver #(
    parameter int TILE_W     = 32,
    parameter int TILE_H     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 start,
    input  logic [15:0]                          tile_px,
    input  logic [15:0]                          tile_py,
    input  logic [7:0]                           bg_r,
    input  logic [7:0]                           bg_g,
    input  logic [7:0]                           bg_b,
    input  logic                                 clear_en,
    output logic                                 busy,
    output logic                                 done,
    output logic [$clog2(TILE_W*TILE_H)-1:0]     tb_rd_addr,
    input  logic [63:0]                          tb_rd_data,
    output logic [$clog2(TILE_W*TILE_H)-1:0]     tb_wr_addr,
    output logic [63:0]                          tb_wr_data,
    output logic                                 tb_wr_en,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [15:0]                          out_x,
    output logic [15:0]                          out_y,
    output logic [23:0]                          out_rgb
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int TXW  = $clog2(TILE_W);
    localparam int TYW  = $clog2(TILE_H);
    localparam int AW   = TXW + TYW;
    localparam int NPIX = TILE_W * TILE_H;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);
    localparam int FW   = 56;                      // {x[15:0], y[15:0], rgb[23:0]}

    localparam logic [AW-1:0]   C_LAST_ADDR    = AW'(NPIX - 1);
    localparam logic [PW-1:0]   C_LAST_SLOT    = PW'(FIFO_DEPTH - 1);
    localparam logic [CW+1:0]   C_CREDIT_LIMIT = (CW + 2)'(FIFO_DEPTH);
    localparam logic [9:0]      C_CH_MAX       = 10'h3FF;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Per-channel arithmetic
    // ------------------------------------------------------------------
    // Out-of-range u0.10 values (anything at or above 1.0) clamp to 1023.
    function automatic logic [9:0] clamp10(input logic [15:0] v);
        return (|v[15:10]) ? C_CH_MAX : v[9:0];
    endfunction

    // c + bg * (1 - a), with c and a already clamped; bg is widened to
    // 10 bits by a left shift, so 0xFF maps to 1020 rather than 1023.
    function automatic logic [7:0] blend(input logic [9:0] c,
                                         input logic [9:0] a,
                                         input logic [7:0] bg);
        logic [10:0] rem;
        logic [20:0] prod;
        logic [10:0] sum;
        logic [9:0]  sat;
        rem  = 11'd1024 - {1'b0, a};
        prod = 21'({bg, 2'b00}) * 21'(rem);
        sum  = {1'b0, c} + prod[20:10];
        sat  = sum[10] ? C_CH_MAX : sum[9:0];
        return sat[9:2];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [AW-1:0]   ptr_q, ptr_d;             // next address to issue

    // Latched job parameters
    logic [15:0]     px_q, py_q;
    logic [7:0]      bgr_q, bgg_q, bgb_q;
    logic            clr_q;

    // Stage 0: address on the read port
    logic            s0_vld_q;
    logic [AW-1:0]   rd_addr_q;
    // Stage 1: read data valid on tb_rd_data this cycle
    logic            s1_vld_q;
    logic [AW-1:0]   s1_addr_q;
    // Stage 2: captured channels, composited combinationally
    logic            s2_vld_q;
    logic [9:0]      s2_r_q, s2_g_q, s2_b_q, s2_a_q;
    logic [15:0]     s2_x_q, s2_y_q;

    // Output FIFO
    logic [FW-1:0]   fifo_q [FIFO_DEPTH];
    logic [PW-1:0]   wp_q, rp_q;
    logic [CW-1:0]   cnt_q;

    // Combinational
    logic            w_issue;
    logic [AW-1:0]   w_issue_addr;
    logic            w_push;
    logic            w_pop;
    logic [CW+1:0]   w_pending;
    logic            w_credit_ok;
    logic            w_drained;
    logic [23:0]     w_rgb;
    logic [TXW-1:0]  w_tx;
    logic [TYW-1:0]  w_ty;

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    assign w_push = s2_vld_q;
    assign w_pop  = (cnt_q != '0) && out_ready;

    // Everything issued but not yet popped. A pop in this cycle frees its
    // slot at the same edge the new read is issued, which keeps the stream
    // at one pixel per clock while the FIFO can still never overflow.
    assign w_pending = (CW + 2)'(cnt_q)
                     + (CW + 2)'(s0_vld_q)
                     + (CW + 2)'(s1_vld_q)
                     + (CW + 2)'(s2_vld_q)
                     - (CW + 2)'(w_pop);
    assign w_credit_ok = (w_pending < C_CREDIT_LIMIT);

    // Empty once the pipeline is idle and the last FIFO entry leaves now.
    assign w_drained = !s0_vld_q && !s1_vld_q && !s2_vld_q &&
                       ((cnt_q == '0) || ((cnt_q == CW'(1)) && w_pop));

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        w_issue      = 1'b0;
        w_issue_addr = ptr_q;
        case (state_q)
            S_IDLE: begin
                // Address 0 goes out straight away; the pipeline and FIFO
                // are always empty here.
                if (start) begin
                    state_d      = S_RUN;
                    w_issue      = 1'b1;
                    w_issue_addr = '0;
                    ptr_d        = AW'(1);
                end
            end
            S_RUN: begin
                if (w_credit_ok) begin
                    w_issue = 1'b1;
                    ptr_d   = ptr_q + 1'b1;
                    if (ptr_q == C_LAST_ADDR) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (w_drained) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

    // ------------------------------------------------------------------
    // Job parameter latch
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            px_q  <= '0;
            py_q  <= '0;
            bgr_q <= '0;
            bgg_q <= '0;
            bgb_q <= '0;
            clr_q <= 1'b0;
        end else if ((state_q == S_IDLE) && start) begin
            px_q  <= tile_px;
            py_q  <= tile_py;
            bgr_q <= bg_r;
            bgg_q <= bg_g;
            bgb_q <= bg_b;
            clr_q <= clear_en;
        end
    end

    // ------------------------------------------------------------------
    // Read / capture pipeline
    // ------------------------------------------------------------------
    assign w_tx = s1_addr_q[TXW-1:0];
    assign w_ty = s1_addr_q[AW-1:TXW];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s0_vld_q  <= 1'b0;
            rd_addr_q <= '0;
            s1_vld_q  <= 1'b0;
            s1_addr_q <= '0;
            s2_vld_q  <= 1'b0;
            s2_r_q    <= '0;
            s2_g_q    <= '0;
            s2_b_q    <= '0;
            s2_a_q    <= '0;
            s2_x_q    <= '0;
            s2_y_q    <= '0;
        end else begin
            s0_vld_q <= w_issue;
            if (w_issue) begin
                rd_addr_q <= w_issue_addr;
            end

            s1_vld_q <= s0_vld_q;
            if (s0_vld_q) begin
                s1_addr_q <= rd_addr_q;
            end

            s2_vld_q <= s1_vld_q;
            if (s1_vld_q) begin
                s2_r_q <= clamp10(tb_rd_data[15:0]);
                s2_g_q <= clamp10(tb_rd_data[31:16]);
                s2_b_q <= clamp10(tb_rd_data[47:32]);
                s2_a_q <= clamp10(tb_rd_data[63:48]);
                s2_x_q <= px_q + 16'(w_tx);
                s2_y_q <= py_q + 16'(w_ty);
            end
        end
    end

    assign tb_rd_addr = rd_addr_q;

    // The clear lands in the same cycle the data is on the read port, so a
    // word is zeroed only after its contents have been sampled.
    assign tb_wr_en   = s1_vld_q & clr_q;
    assign tb_wr_addr = s1_addr_q;
    assign tb_wr_data = '0;

    // ------------------------------------------------------------------
    // Composite
    // ------------------------------------------------------------------
    assign w_rgb = {blend(s2_b_q, s2_a_q, bgb_q),
                    blend(s2_g_q, s2_a_q, bgg_q),
                    blend(s2_r_q, s2_a_q, bgr_q)};

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (w_push) begin
                fifo_q[wp_q] <= {s2_x_q, s2_y_q, w_rgb};
                wp_q         <= (wp_q == C_LAST_SLOT) ? '0 : wp_q + 1'b1;
            end
            if (w_pop) begin
                rp_q <= (rp_q == C_LAST_SLOT) ? '0 : rp_q + 1'b1;
            end
            cnt_q <= cnt_q + CW'(w_push) - CW'(w_pop);
        end
    end

    // The head entry is held until popped, so a stalled output is stable.
    assign out_valid = (cnt_q != '0);
    assign out_x     = fifo_q[rp_q][55:40];
    assign out_y     = fifo_q[rp_q][39:24];
    assign out_rgb   = fifo_q[rp_q][23:0];

endmodule
`default_nettype wire

// File: tb/tb_tile_resolver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tile_resolver
//  Purpose  : Self-checking bench for tile_resolver. A tile buffer model
//             answers reads one cycle late and applies clears; expected
//             pixels are queued when a tile is started and compared in order
//             as the DUT hands them off.
//  Revision : 1.0  initial release
// ============================================================================
module tb_tile_resolver;

    localparam int NPIX  = 1024;
    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [15:0] tile_px, tile_py;
    logic [7:0]  bg_r, bg_g, bg_b;
    logic        clear_en;
    logic        busy, done;
    logic [9:0]  tb_rd_addr;
    logic [63:0] tb_rd_data;
    logic [9:0]  tb_wr_addr;
    logic [63:0] tb_wr_data;
    logic        tb_wr_en;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_x, out_y;
    logic [23:0] out_rgb;

    tile_resolver #(
        .TILE_W     (32),
        .TILE_H     (32),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .tile_px    (tile_px),
        .tile_py    (tile_py),
        .bg_r       (bg_r),
        .bg_g       (bg_g),
        .bg_b       (bg_b),
        .clear_en   (clear_en),
        .busy       (busy),
        .done       (done),
        .tb_rd_addr (tb_rd_addr),
        .tb_rd_data (tb_rd_data),
        .tb_wr_addr (tb_wr_addr),
        .tb_wr_data (tb_wr_data),
        .tb_wr_en   (tb_wr_en),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_x      (out_x),
        .out_y      (out_y),
        .out_rgb    (out_rgb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------------
    // Bookkeeping
    // ------------------------------------------------------------------
    int          n_cmp = 0;
    int          n_err = 0;

    logic [63:0] mem [NPIX];
    logic [55:0] sb_q [$];

    logic [15:0] cur_px, cur_py;
    logic [7:0]  cur_r, cur_g, cur_b;

    int          hs_cnt, issued, next_rd, max_ahead;
    int          wr_cnt, wr_dup, wr_bad, stab_bad, done_cnt;
    int          epoch = 0;
    int          wr_epoch [NPIX];
    bit          first_seen;
    time         t_start, t_done, t_first;
    logic [15:0] probe_x [2];
    logic [15:0] probe_y [2];
    bit          probe_hit [2];
    logic [23:0] probe_rgb [2];

    int          ready_mode = 0;
    int          stall_left = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: c + ((bg*4) * (1024 - a)) / 1024, inputs clamped to 1023,
    // result clamped to 1023, then reduced to 8 bits.
    function automatic int ch8(input int c, input int a, input int bg);
        int ac, cc, v;
        ac = (a > 1023) ? 1023 : a;
        cc = (c > 1023) ? 1023 : c;
        v  = cc + ((bg * 4) * (1024 - ac)) / 1024;
        if (v > 1023) v = 1023;
        return v / 4;
    endfunction

    function automatic logic [55:0] exp_pix(input logic [63:0] w, input int idx);
        logic [15:0] x, y;
        int r, g, b, a;
        x = cur_px + 16'(idx % 32);
        y = cur_py + 16'(idx / 32);
        a = int'(w[63:48]);
        r = ch8(int'(w[15:0]),  a, int'(cur_r));
        g = ch8(int'(w[31:16]), a, int'(cur_g));
        b = ch8(int'(w[47:32]), a, int'(cur_b));
        return {x, y, 8'(b), 8'(g), 8'(r)};
    endfunction

    // ------------------------------------------------------------------
    // Tile buffer model: read data one cycle after the address
    // ------------------------------------------------------------------
    initial begin
        tb_rd_data = '0;
        forever begin
            @(posedge clk);
            if (tb_wr_en) mem[tb_wr_addr] <= tb_wr_data;
            tb_rd_data <= mem[tb_rd_addr];
        end
    end

    // ------------------------------------------------------------------
    // Downstream ready pattern
    // ------------------------------------------------------------------
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (ready_mode == 0 || hs_cnt < 300) begin
                out_ready = 1'b1;
            end else if (stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = ~out_ready;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor (samples on the falling edge)
    // ------------------------------------------------------------------
    initial begin
        logic [55:0] held;
        logic [9:0]  prev_rd;
        bit          stall_prev;
        held       = '0;
        prev_rd    = '0;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (done) done_cnt++;
            if (!reset_n) begin
                stall_prev = 1'b0;
            end else begin
                if (stall_prev && (!out_valid || {out_x, out_y, out_rgb} != held))
                    stab_bad++;
                if (busy && next_rd < NPIX && int'(tb_rd_addr) == next_rd) begin
                    issued++;
                    next_rd++;
                end
                if (issued - hs_cnt > max_ahead) max_ahead = issued - hs_cnt;
                if (tb_wr_en) begin
                    wr_cnt++;
                    if (wr_epoch[tb_wr_addr] == epoch) wr_dup++;
                    wr_epoch[tb_wr_addr] = epoch;
                    if (tb_wr_addr != prev_rd || tb_wr_data != 64'd0) wr_bad++;
                end
                prev_rd = tb_rd_addr;
                if (out_valid && !first_seen) begin
                    first_seen = 1'b1;
                    t_first    = $time;
                end
                if (out_valid && out_ready) begin
                    hs_cnt++;
                    if (sb_q.size() == 0) begin
                        check("sb_extra_pixel", {out_x, out_y, out_rgb}, 64'hDEAD);
                    end else begin
                        check("pixel", {out_x, out_y, out_rgb}, sb_q.pop_front());
                    end
                    for (int k = 0; k < 2; k++) begin
                        if (out_x == probe_x[k] && out_y == probe_y[k]) begin
                            probe_hit[k] = 1'b1;
                            probe_rgb[k] = out_rgb;
                        end
                    end
                end
                stall_prev = out_valid && !out_ready;
                held       = {out_x, out_y, out_rgb};
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic fill_zero();
        for (int i = 0; i < NPIX; i++) mem[i] = 64'd0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < NPIX; i++) begin
            if (i % 4 == 0)
                mem[i] = {$urandom, $urandom};
            else
                mem[i] = {16'($urandom_range(0, 1023)), 16'($urandom_range(0, 1023)),
                          16'($urandom_range(0, 1023)), 16'($urandom_range(0, 1023))};
        end
    endtask

    task automatic start_tile(input logic [15:0] px, input logic [15:0] py,
                              input logic [7:0] r, input logic [7:0] g,
                              input logic [7:0] b, input logic clr);
        cur_px = px; cur_py = py; cur_r = r; cur_g = g; cur_b = b;
        sb_q.delete();
        for (int i = 0; i < NPIX; i++) sb_q.push_back(exp_pix(mem[i], i));
        epoch++;
        hs_cnt = 0; issued = 0; next_rd = 0; max_ahead = 0;
        wr_cnt = 0; wr_dup = 0; wr_bad = 0; stab_bad = 0;
        first_seen = 1'b0;
        probe_hit[0] = 1'b0;
        probe_hit[1] = 1'b0;
        @(posedge clk);
        #1;
        tile_px = px; tile_py = py; bg_r = r; bg_g = g; bg_b = b;
        clear_en = clr;
        start = 1'b1;
        @(posedge clk);
        t_start = $time;
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got    = 1'b1;
                t_done = $time;
                break;
            end
        end
        check("done_seen", 64'(got), 64'd1);
        @(negedge clk);
        check("busy_fall", 64'(busy), 64'd0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int dc0;
        int nz;
        bit reached;
        reset_n  = 1'b0;
        start    = 1'b0;
        tile_px  = '0; tile_py = '0;
        bg_r     = '0; bg_g = '0; bg_b = '0;
        clear_en = 1'b0;
        t_done   = 0;
        t_first  = 0;
        done_cnt = 0;
        for (int i = 0; i < NPIX; i++) wr_epoch[i] = 0;
        probe_x[0] = '0; probe_y[0] = '0;
        probe_x[1] = '0; probe_y[1] = '0;
        fill_zero();

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {60'd0, busy, done, tb_wr_en, out_valid}, 64'd0);
        check("rst_addr", {44'd0, tb_rd_addr, tb_wr_addr}, 64'd0);
        check("rst_wdata", tb_wr_data, 64'd0);
        check("rst_out", {8'd0, out_x, out_y, out_rgb}, 64'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 1: all-zero tile over background, full throughput
        ready_mode = 0;
        start_tile(16'd32, 16'd64, 8'h40, 8'h80, 8'hFF, 1'b0);
        wait_done(3000);
        check("done_cycles_inclusive", 64'((t_done - t_start + 5) / 10 + 1), 64'd1029);
        check("first_valid_cycle", 64'((t_first - t_start + 5) / 10), 64'd4);
        check("t1_handshakes", 64'(hs_cnt), 64'd1024);
        check("t1_sb_left", 64'(sb_q.size()), 64'd0);
        check("t1_no_clears", 64'(wr_cnt), 64'd0);

        // 2: single non-zero word, black background
        fill_zero();
        mem[10'h021] = {16'd1020, 16'd0, 16'd512, 16'd1020};
        probe_x[0] = 16'd65; probe_y[0] = 16'd97;
        probe_x[1] = 16'd64; probe_y[1] = 16'd96;
        start_tile(16'd64, 16'd96, 8'h00, 8'h00, 8'h00, 1'b0);
        wait_done(3000);
        check("t2_probe_hit", 64'(probe_hit[0]), 64'd1);
        check("t2_probe_rgb", 64'(probe_rgb[0]), 64'h0080FF);
        check("t2_origin_rgb", 64'(probe_rgb[1]), 64'h000000);
        check("t2_handshakes", 64'(hs_cnt), 64'd1024);

        // 3: random tile, saturation words, clears, backpressure, wrap-around origin
        fill_random();
        mem[5] = {16'd0, 16'd100, 16'd200, 16'd1023};
        mem[6] = {16'd0, 16'd0, 16'd0, 16'hFFFF};
        probe_x[0] = 16'hFFF5; probe_y[0] = 16'hFFFE;
        probe_x[1] = 16'hFFF6; probe_y[1] = 16'hFFFE;
        ready_mode = 1;
        stall_left = 100;
        start_tile(16'hFFF0, 16'hFFFE, 8'hFF, 8'(($urandom)), 8'(($urandom)), 1'b1);
        wait_done(8000);
        ready_mode = 0;
        check("sat_r1023_hit", 64'(probe_hit[0]), 64'd1);
        check("sat_r1023", 64'(probe_rgb[0][7:0]), 64'hFF);
        check("sat_rffff", 64'(probe_rgb[1][7:0]), 64'hFF);
        check("t3_handshakes", 64'(hs_cnt), 64'd1024);
        check("t3_sb_left", 64'(sb_q.size()), 64'd0);
        check("reads_ahead_bound", 64'(max_ahead <= DEPTH), 64'd1);
        check("stall_stable", 64'(stab_bad), 64'd0);
        check("clear_count", 64'(wr_cnt), 64'd1024);
        check("clear_dup", 64'(wr_dup), 64'd0);
        check("clear_after_read", 64'(wr_bad), 64'd0);
        nz = 0;
        for (int i = 0; i < NPIX; i++) if (mem[i] != 64'd0) nz++;
        check("buffer_zero", 64'(nz), 64'd0);

        // 4: reset mid-tile, then a clean restart
        fill_random();
        start_tile(16'd128, 16'd0, 8'h12, 8'h34, 8'h56, 1'b0);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (hs_cnt >= 500) begin
                reached = 1'b1;
                break;
            end
        end
        check("t4_reach_500", 64'(reached), 64'd1);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        dc0 = done_cnt;
        @(posedge clk);
        @(negedge clk);
        check("rst_mid_ctrl", {61'd0, out_valid, busy, tb_wr_en}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        sb_q.delete();
        repeat (30) @(negedge clk);
        check("rst_no_done", 64'(done_cnt - dc0), 64'd0);
        start_tile(16'd128, 16'd0, 8'h12, 8'h34, 8'h56, 1'b0);
        wait_done(3000);
        check("t4_handshakes", 64'(hs_cnt), 64'd1024);
        check("t4_sb_left", 64'(sb_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/tile_resolver.md
# tile_resolver

Reads back a finished 32x32 tile from the tile buffer after all splats for that tile have been rasterized. It composites each pixel over a background colour, converts the u0.10 channels to 8-bit, and streams pixels with their screen coordinates to the framebuffer writer over a valid/ready handshake. It can optionally clear each tile-buffer word as it reads it, so the buffer is ready for the next tile. It owns the tile buffer read/write ports only while `busy`; the top level muxes the ports between this block and the rasterizer.

## Interface
Parameters:
- `TILE_W`, 32, tile width; power of two.
- `TILE_H`, 32, tile height; power of two.
- `FIFO_DEPTH`, 4, output FIFO depth; must be at least 3.

Ports:
- `clk`  in  1  sole clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `start`  in  1  single-cycle pulse that begins a resolve; ignored while `busy`.
- `tile_px`, `tile_py`  in  16 each  tile origin in pixels; latched on `start`.
- `bg_r`, `bg_g`, `bg_b`  in  8 each  background colour; latched on `start`.
- `clear_en`  in  1  when 1, zero each word after it is read; latched on `start`.
- `busy`  out  1  high from the cycle after `start` until the `done` cycle, inclusive.
- `done`  out  1  one-cycle pulse when the last pixel has been accepted downstream.
- `tb_rd_addr`  out  10  registered read address, formed as {ty, tx}.
- `tb_rd_data`  in  64  {A, B, G, R}, 16 bits each, u0.10 in the low bits. Data for an address is valid one cycle after that address appears on the port.
- `tb_wr_addr`  out  10  clear address.
- `tb_wr_data`  out  64  always 0.
- `tb_wr_en`  out  1  clear strobe.
- `out_valid`  out  1  pixel available.
- `out_ready`  in  1  downstream accepts a pixel.
- `out_x`, `out_y`  out  16 each  screen coordinates: `tile_px + tx`, `tile_py + ty`, modulo 2^16.
- `out_rgb`  out  24  {B, G, R}, 8 bits each.

## Operation
- States:
  - S_IDLE: on `start`, latch the inputs, set read pointer = 0, go to S_RUN.
  - S_RUN: issue reads, one per cycle at most, while credits allow. After the read of address 1023 is issued, go to S_DRAIN.
  - S_DRAIN: wait until the pipeline and FIFO are empty and the last pixel has been handshaken, then go to S_DONE.
  - S_DONE: pulse `done`, go to S_IDLE.
- Scan order is raster: ty outer, tx inner. The address is {ty[4:0], tx[4:0]}. Each address is read exactly once.
- Credit rule: issue a read only when (FIFO occupancy + reads in flight) < `FIFO_DEPTH`. Under this rule the FIFO never overflows and no data is dropped.
- Capture stage, in the cycle the read data is valid:
  - register the A/B/G/R channels, the address and the coordinates;
  - if `clear_en`, assert `tb_wr_en` with `tb_wr_addr` = that address for one cycle.
- Composite stage, one cycle, result pushed into the FIFO. Per channel:
  - `a' = min(A, 1023)`
  - `rem = 1024 - a'`, 11 bits.
  - `c = min(C, 1023) + (((bg << 2) * rem) >> 10)`
  - saturate `c` to 1023.
  - `out8 = c >> 2`.
- Output: the FIFO head drives `out_*`. A pop occurs when `out_valid && out_ready`. While stalled, `out_*` stay stable.
- Width rules: the product `(bg << 2) * rem` is 21 bits; the sum before saturation is 11 bits. Bits [63:58], [47:42], [31:26] and [15:10] of the read data are ignored except where they feed the min() clamp.
- Reset: `reset_n` = 0 at any point, including mid-tile, aborts the resolve. The FIFO and pipeline are flushed, the state returns to S_IDLE, and `done` is not pulsed. Tile words not yet cleared are left unchanged.

## Timing
- Reset values: `busy`, `done`, `tb_wr_en`, `out_valid` = 0. `tb_rd_addr`, `tb_wr_addr`, `tb_wr_data`, `out_x`, `out_y`, `out_rgb` = 0.
- `start` is sampled at edge 0:
  - address 0 is on `tb_rd_addr` in cycle 1;
  - data is captured in cycle 2, and the clear write (if enabled) happens in cycle 2;
  - the composite is computed in cycle 3;
  - `out_valid` rises in cycle 4.
- With `out_ready` held at 1, throughput is 1 pixel per clock. Expected duration is 1024 + 5 cycles from `start` to `done`.
- `done` asserts in the cycle after the handshake of pixel 1023, and `busy` falls the cycle after `done`.
- `start` coinciding with `done`: ignored. A new `start` is accepted only from S_IDLE.

## Test plan
- All-zero tile, bg = (R 0x40, G 0x80, B 0xFF), `clear_en` = 0, `out_ready` = 1 → 1024 pixels, each `out_rgb` = 0xFF8040, in raster order. x runs 0..31 per row from `tile_px`. `done` arrives 1029 cycles after `start`, and there are no `tb_wr_en` pulses.
- Word at 0x021 = {A 1020, B 0, G 512, R 1020}, bg = 0, tile origin (64, 96) → the pixel at (65, 97) has `out_rgb` = 0x0080FF. All other pixels are 0.
- Saturation: R = 1023, A = 0, bg_r = 0xFF → c = 2043 clamps to 1023, so R out = 0xFF. Also check an out-of-range word with R = 0xFFFF → R out = 0xFF.
- Backpressure: hold `out_ready` = 0 for 100 cycles mid-tile, then toggle it 1/0 → at most `FIFO_DEPTH` reads ahead of the handshakes, and `out_*` stay stable while stalled. Exactly 1024 unique coordinates, with no drops or duplicates.
- `clear_en` = 1 on a random tile → exactly 1024 `tb_wr_en` pulses, each address written once, each one cycle after its read. The buffer is all zero after `done`.
- Pull `reset_n` low after 500 handshakes → the next cycle has `out_valid` = `busy` = `tb_wr_en` = 0, and no `done` pulse. A subsequent `start` restarts from address 0 and completes all 1024 pixels.
